// File: rtl/ps_fetch_seq.sv
// rtl/ps_fetch_seq.sv - program-sequencer fetch front end with PC stack
module ps_fetch_seq #(
    parameter int PMA_SIZE = 3,
    parameter int PMD_SIZE = 32,
    parameter int STK_AW   = 2,
    parameter logic [PMA_SIZE-1:0] RESET_VEC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_stall,
    input  logic [PMD_SIZE-1:0] pm_ps_op,
    output logic                ps_pm_cslt,
    output logic [PMA_SIZE-1:0] ps_pm_add,
    output logic                ps_pm_wrb,
    output logic [PMD_SIZE-1:0] ps_inst,
    output logic                ps_inst_vld,
    output logic [PMA_SIZE-1:0] ps_inst_addr,
    output logic                ps_halted,
    output logic [STK_AW:0]     ps_stk_lvl,
    output logic                ps_stk_ovf,
    output logic                ps_stk_unf
);

    localparam logic [3:0] OP_JUMP = 4'h3;
    localparam logic [3:0] OP_CALL = 4'h4;
    localparam logic [3:0] OP_RTS  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [STK_AW:0] STK_FULL = (STK_AW+1)'(2**STK_AW);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t                state, next_state;
    logic                  pend_vld;
    logic [PMA_SIZE-1:0]   pend_addr;
    logic [PMA_SIZE-1:0]   pend_inc;
    logic [PMA_SIZE-1:0]   stk [2**STK_AW];
    logic [PMA_SIZE-1:0]   stk_top;
    logic [STK_AW-1:0]     top_idx;
    logic [3:0]            opc;
    logic [PMA_SIZE-1:0]   tgt;
    logic                  consume;
    logic                  push, pop;

    assign ps_inst      = pm_ps_op;
    assign ps_inst_vld  = pend_vld & (state == RUN);
    assign ps_inst_addr = pend_addr;
    assign ps_halted    = (state == HALTED);
    assign ps_pm_wrb    = 1'b0;

    assign opc      = pm_ps_op[PMD_SIZE-1 -: 4];
    assign tgt      = pm_ps_op[PMA_SIZE-1:0];
    assign consume  = ps_inst_vld & ~ps_stall;
    assign pend_inc = pend_addr + 1'b1;
    assign top_idx  = ps_stk_lvl[STK_AW-1:0] - 1'b1;
    assign stk_top  = stk[top_idx];

    // Redirect decisions are combinational on the returned word so branches cost no bubble
    always_comb begin
        next_state = state;
        ps_pm_cslt = 1'b0;
        ps_pm_add  = pend_addr;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            BOOT: begin
                ps_pm_cslt = reset;
                ps_pm_add  = RESET_VEC;
                next_state = RUN;
            end
            RUN: begin
                ps_pm_cslt = 1'b1;
                if (consume) begin
                    case (opc)
                        OP_JUMP: ps_pm_add = tgt;
                        OP_CALL: begin
                            ps_pm_add = tgt;
                            push      = 1'b1;
                        end
                        OP_RTS: begin
                            pop       = 1'b1;
                            ps_pm_add = (ps_stk_lvl == '0) ? pend_inc : stk_top;
                        end
                        OP_HALT: begin
                            ps_pm_cslt = 1'b0;
                            next_state = HALTED;
                        end
                        default: ps_pm_add = pend_inc;
                    endcase
                end
            end
            default: begin
                ps_pm_cslt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            ps_stk_lvl <= '0;
            ps_stk_ovf <= 1'b0;
            ps_stk_unf <= 1'b0;
        end else begin
            state     <= next_state;
            pend_vld  <= ps_pm_cslt;
            pend_addr <= ps_pm_add;
            if (push) begin
                if (ps_stk_lvl == STK_FULL) ps_stk_ovf <= 1'b1;
                else                        ps_stk_lvl <= ps_stk_lvl + 1'b1;
            end
            if (pop) begin
                if (ps_stk_lvl == '0) ps_stk_unf <= 1'b1;
                else                  ps_stk_lvl <= ps_stk_lvl - 1'b1;
            end
        end
    end

    // Stack contents need no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (push && ps_stk_lvl != STK_FULL)
            stk[ps_stk_lvl[STK_AW-1:0]] <= pend_inc;
    end

endmodule

// File: tb/tb_ps_fetch_seq.sv
// tb/tb_ps_fetch_seq.sv - directed table-driven bench for ps_fetch_seq
module tb_ps_fetch_seq;

    logic        clk;
    logic        reset;
    logic        ps_stall;
    logic [31:0] pm_ps_op;
    logic        ps_pm_cslt;
    logic [2:0]  ps_pm_add;
    logic        ps_pm_wrb;
    logic [31:0] ps_inst;
    logic        ps_inst_vld;
    logic [2:0]  ps_inst_addr;
    logic        ps_halted;
    logic [2:0]  ps_stk_lvl;
    logic        ps_stk_ovf;
    logic        ps_stk_unf;

    logic [31:0] mem [8];
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] RTS_W = 32'h5000_0000;

    ps_fetch_seq #(.PMA_SIZE(3), .PMD_SIZE(32), .STK_AW(2), .RESET_VEC(3'd0)) dut (
        .clk(clk), .reset(reset), .ps_stall(ps_stall), .pm_ps_op(pm_ps_op),
        .ps_pm_cslt(ps_pm_cslt), .ps_pm_add(ps_pm_add), .ps_pm_wrb(ps_pm_wrb),
        .ps_inst(ps_inst), .ps_inst_vld(ps_inst_vld), .ps_inst_addr(ps_inst_addr),
        .ps_halted(ps_halted), .ps_stk_lvl(ps_stk_lvl),
        .ps_stk_ovf(ps_stk_ovf), .ps_stk_unf(ps_stk_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) pm_ps_op <= ps_pm_cslt ? mem[ps_pm_add] : 32'h0;

    typedef struct {
        logic       stall;
        logic       fill;
        logic       cslt;
        logic [2:0] add;
        logic       vld;
        logic [2:0] ia;
        logic [2:0] lvl;
        logic       halt;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic st, logic cs, int ad, logic v, int ia,
                                int lv, logic h, logic o, logic u, logic f);
        vec_t r;
        r.stall = st; r.cslt = cs; r.add = 3'(ad); r.vld = v; r.ia = 3'(ia);
        r.lvl = 3'(lv); r.halt = h; r.ovf = o; r.unf = u; r.fill = f;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".cslt"}, 32'(ps_pm_cslt), 32'd0);
        chk({tag, ".add"}, 32'(ps_pm_add), 32'd0);
        chk({tag, ".vld"}, 32'(ps_inst_vld), 32'd0);
        chk({tag, ".iaddr"}, 32'(ps_inst_addr), 32'd0);
        chk({tag, ".halted"}, 32'(ps_halted), 32'd0);
        chk({tag, ".lvl"}, 32'(ps_stk_lvl), 32'd0);
        chk({tag, ".ovf"}, 32'(ps_stk_ovf), 32'd0);
        chk({tag, ".unf"}, 32'(ps_stk_unf), 32'd0);
    endtask

    task automatic clear_mem;
        for (int k = 0; k < 8; k++) mem[k] = 32'h0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        ps_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run_vecs(input string tag);
        string nm;
        foreach (vq[i]) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            ps_stall = vq[i].stall;
            #1;
            nm = $sformatf("%s[%0d]", tag, i);
            chk({nm, ".cslt"}, 32'(ps_pm_cslt), 32'(vq[i].cslt));
            if (vq[i].cslt) chk({nm, ".add"}, 32'(ps_pm_add), 32'(vq[i].add));
            chk({nm, ".vld"}, 32'(ps_inst_vld), 32'(vq[i].vld));
            if (vq[i].vld) chk({nm, ".iaddr"}, 32'(ps_inst_addr), 32'(vq[i].ia));
            chk({nm, ".lvl"}, 32'(ps_stk_lvl), 32'(vq[i].lvl));
            chk({nm, ".halted"}, 32'(ps_halted), 32'(vq[i].halt));
            chk({nm, ".ovf"}, 32'(ps_stk_ovf), 32'(vq[i].ovf));
            chk({nm, ".unf"}, 32'(ps_stk_unf), 32'(vq[i].unf));
            chk({nm, ".wrb"}, 32'(ps_pm_wrb), 32'd0);
            if (vq[i].fill)
                for (int k = 0; k < 5; k++) mem[k] = RTS_W;
        end
        ps_stall = 1'b0;
        vq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ps_stall = 1'b0;
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");

        // sequential wrap over all-NOP memory
        for (int k = 0; k < 10; k++)
            vq.push_back(mk(0, 1, k % 8, k > 0, (k + 7) % 8, 0, 0, 0, 0, 0));
        do_reset();
        run_vecs("seq");

        // JUMP at 2 to 6
        clear_mem();
        mem[2] = 32'h3000_0006;
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 6, 1, 2, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 7, 1, 6, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 1, 7, 0, 0, 0, 0, 0));
        do_reset();
        run_vecs("jump");

        // CALL at 1 to 5, RTS at 5
        clear_mem();
        mem[1] = 32'h4000_0005;
        mem[5] = RTS_W;
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 5, 1, 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2, 1, 5, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 3, 1, 2, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 3, 0, 0, 0, 0, 0));
        do_reset();
        run_vecs("call");

        // JUMP at 3 held by a 3-cycle stall
        clear_mem();
        mem[3] = 32'h3000_0006;
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 3, 1, 2, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 3, 1, 3, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 3, 1, 3, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 3, 1, 3, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 6, 1, 3, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 7, 1, 6, 0, 0, 0, 0, 0));
        do_reset();
        run_vecs("stall");

        // five nested CALLs, then RTS chain past empty (memory turns to RTS after the last CALL)
        clear_mem();
        for (int k = 0; k < 5; k++) mem[k] = 32'h4000_0000 | 32'(k + 1);
        mem[5] = RTS_W;
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2, 1, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 3, 1, 2, 2, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 3, 3, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 5, 1, 4, 4, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 4, 1, 5, 4, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 3, 1, 4, 3, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 2, 1, 3, 2, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 1, 1, 2, 1, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 2, 1, 1, 0, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 3, 1, 2, 0, 0, 1, 1, 0));
        do_reset();
        run_vecs("stack");

        // asynchronous reset mid-cycle while running with sticky flags set
        #3 reset = 1'b0;
        #1;
        chk_idle("arst_run");

        // HALT at 4
        clear_mem();
        mem[4] = 32'hF000_0000;
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 3, 1, 2, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 3, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 4, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        do_reset();
        run_vecs("halt");

        #3 reset = 1'b0;
        #1;
        chk_idle("arst_halt");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("refetch.cslt", 32'(ps_pm_cslt), 32'd1);
        chk("refetch.add", 32'(ps_pm_add), 32'd0);
        @(posedge clk);
        #2;
        chk("refetch1.add", 32'(ps_pm_add), 32'd1);
        chk("refetch1.vld", 32'(ps_inst_vld), 32'd1);
        chk("refetch1.iaddr", 32'(ps_inst_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps_fetch_seq.md
Name: ps_fetch_seq

Overview:
- Program-sequencer fetch front end. It is the initiator on the PM read port: it drives chip-select, address and write-strobe to program memory and consumes the registered instruction word returned one cycle later.
- Resolves sequential flow, JUMP, CALL/RTS (via an internal PC stack) and HALT with zero bubbles.
- Presents each fetched instruction, with its address, to the decoder.
- Honours a decoder stall by replaying the fetch.

Parameters:
- PMA_SIZE, 3, PM address width; PC wraps modulo 2**PMA_SIZE.
- PMD_SIZE, 32, PM instruction width.
- STK_AW, 2, PC stack address width; depth = 2**STK_AW entries.
- RESET_VEC, 0, first fetch address after reset.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- ps_stall, input, 1, decoder not accepting the current instruction this cycle.
- pm_ps_op, input, PMD_SIZE, PM read data. Registered in PM; reflects the address presented on the previous edge; reads 0 when cslt was low.
- ps_pm_cslt, output, 1, PM chip select.
- ps_pm_add, output, PMA_SIZE, PM address.
- ps_pm_wrb, output, 1, PM write strobe; tied 0 (read-only).
- ps_inst, output, PMD_SIZE, instruction to decoder (= pm_ps_op).
- ps_inst_vld, output, 1, ps_inst holds a fetched word.
- ps_inst_addr, output, PMA_SIZE, address of ps_inst.
- ps_halted, output, 1, HALT executed.
- ps_stk_lvl, output, STK_AW+1, stack occupancy.
- ps_stk_ovf, output, 1, sticky: push attempted while full.
- ps_stk_unf, output, 1, sticky: pop attempted while empty.

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: state BOOT, ps_pm_cslt=0, ps_pm_add=RESET_VEC, ps_inst_vld=0, ps_inst_addr=0, ps_halted=0, ps_stk_lvl=0, ps_stk_ovf=0, ps_stk_unf=0. Stack contents are don't-care.
- Internal registers:
  - pend_vld: cslt was issued last cycle.
  - pend_addr: address issued last cycle.
- Outputs: ps_inst=pm_ps_op; ps_inst_vld=pend_vld & (state==RUN); ps_inst_addr=pend_addr.
- Decode on pm_ps_op[PMD_SIZE-1:PMD_SIZE-4]:
  - 4'h3 JUMP, 4'h4 CALL, 4'h5 RTS, 4'hF HALT; all other values are sequential.
  - tgt = pm_ps_op[PMA_SIZE-1:0].
- consume = ps_inst_vld & ~ps_stall.
- FSM states:
  - BOOT: drive cslt=1, add=RESET_VEC; go to RUN.
  - RUN: cslt=1. Address is chosen combinationally in the same cycle:
    - ps_stall=1: add=pend_addr (replay); no stack change.
    - consume, sequential: add=pend_addr+1.
    - consume, JUMP: add=tgt.
    - consume, CALL: add=tgt; push pend_addr+1. If the stack is full: push dropped, ps_stk_ovf set, jump still taken.
    - consume, RTS: add=popped top. If the stack is empty: ps_stk_unf set, add=pend_addr+1.
    - consume, HALT: cslt=0; go to HALTED.
  - HALTED: cslt=0, ps_inst_vld=0, ps_halted=1. Leaves only via reset.
- Latency:
  - Address to ps_inst is 1 cycle.
  - Taken JUMP/CALL/RTS costs 0 bubbles, because the target is issued in the same cycle the branch is consumed.
- Arithmetic: pend_addr+1 truncates to PMA_SIZE, so 2**PMA_SIZE-1 wraps to 0. Stack entries are PMA_SIZE wide.
- Stall while a branch is visible: no redirect and no push/pop. The branch takes effect on the cycle it is finally consumed.
- ps_stk_ovf and ps_stk_unf stay set until reset.
- Reset mid-operation: all state returns to reset values immediately; the first fetch after release is RESET_VEC.

Test Plan:
- Sequential wrap, PMA_SIZE=3, all-NOP memory:
  - Release reset -> ps_pm_add 0,1,..,7,0,1.
  - ps_inst_addr lags by 1 cycle.
  - cslt=0 only during reset.
- JUMP at 2 with target 6, i.e. word 32'h3000_0006 -> addresses 0,1,2,6,7, no bubble; ps_inst_addr shows 2 then 6.
- CALL/RTS:
  - CALL at 1 to 5, RTS at 5 -> addresses 0,1,5,2,3.
  - ps_stk_lvl goes 0->1->0.
- Stack overflow:
  - STK_AW=2, five nested CALLs -> ps_stk_lvl saturates at 4.
  - ps_stk_ovf=1 after the 5th.
  - Five RTS then one extra -> ps_stk_unf=1; fetch continues at pend_addr+1.
- Stall replay: ps_stall high for 3 cycles while a JUMP at 3 is presented -> ps_pm_add holds 3, ps_inst_addr holds 3; after release, add=target.
- HALT at 4, word 32'hF000_0000 -> cslt=0 and ps_halted=1 next cycle. Reset asserted mid-run -> outputs return to reset values asynchronously; refetch starts at RESET_VEC.
